// File: rtl/noc_pe_eject_buffer_if.sv
// Ejection-side bus bundle: the flit stream arriving from the mesh PE output
// and the payload handshake toward the local processing element.
interface noc_pe_eject_buffer_if #(
  parameter int data_width  = 32,
  parameter int total_width = 34
);
  logic                   i_valid;
  logic [total_width-1:0] i_data;
  logic                   o_valid;
  logic [data_width-1:0]  o_data;
  logic                   i_ready;

  // Driver of the flit stream and consumer of the payload.
  modport master (
    output i_valid,
    output i_data,
    output i_ready,
    input  o_valid,
    input  o_data
  );

  // The eject buffer itself.
  modport slave (
    input  i_valid,
    input  i_data,
    input  i_ready,
    output o_valid,
    output o_data
  );
endinterface

// File: rtl/noc_pe_eject_buffer.sv
// Ejection buffer for one mesh node. Every flit from the mesh PE output is
// absorbed: flits addressed here have their header stripped and the payload
// queued in a first-word-fall-through FIFO. Flits that are misrouted, or that
// arrive while the FIFO is full, are dropped and recorded in sticky flags and
// a saturating drop counter.
module noc_pe_eject_buffer #(
  parameter int X_COORD     = 0,
  parameter int Y_COORD     = 0,
  parameter int data_width  = 32,
  parameter int x_size      = 1,
  parameter int y_size      = 1,
  parameter int total_width = x_size + y_size + data_width,
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  noc_pe_eject_buffer_if.slave     bus,
  input  logic                     i_clr,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow,
  output logic                     o_misroute,
  output logic [CNT_W-1:0]         o_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]     FULL_LVL = LW'(DEPTH);
  localparam logic [x_size-1:0] X_SEL    = x_size'(X_COORD);
  localparam logic [y_size-1:0] Y_SEL    = y_size'(Y_COORD);

  // Saturating increment of the drop counter; holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic [data_width-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level;

  logic [data_width-1:0] payload;
  logic [x_size-1:0]     flit_x;
  logic [y_size-1:0]     flit_y;
  logic                  coord_ok;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  ovf_drop;
  logic                  mis_drop;
  logic                  drop;

  assign payload  = bus.i_data[data_width-1:0];
  assign flit_x   = bus.i_data[data_width +: x_size];
  assign flit_y   = bus.i_data[data_width + x_size +: y_size];
  assign coord_ok = (flit_x == X_SEL) && (flit_y == Y_SEL);

  assign full     = (level == FULL_LVL);
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign pop      = bus.o_valid && bus.i_ready;
  assign push     = bus.i_valid && coord_ok && (!full || pop);
  assign ovf_drop = bus.i_valid && coord_ok && full && !pop;
  assign mis_drop = bus.i_valid && !coord_ok;
  assign drop     = ovf_drop || mis_drop;

  // Output side reads straight from storage; no combinational bypass from
  // the input, and data is forced to zero while empty so it is never X.
  assign bus.o_valid = (level != '0);
  assign bus.o_data  = bus.o_valid ? mem[rd_ptr] : '0;
  assign o_level     = level;

  // Pointer and occupancy bookkeeping; reset discards all stored flits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Payload storage; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= payload;
  end

  // Sticky drop flags and counter; a drop coinciding with clear still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_overflow <= 1'b0;
      o_misroute <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      if (i_clr) begin
        o_overflow <= 1'b0;
        o_misroute <= 1'b0;
      end
      if (ovf_drop) o_overflow <= 1'b1;
      if (mis_drop) o_misroute <= 1'b1;
      if (i_clr)
        o_drop_cnt <= drop ? CNT_W'(1) : '0;
      else if (drop)
        o_drop_cnt <= sat_inc(o_drop_cnt);
    end
  end

endmodule
